// File: rtl/amo_reservation_unit.sv
// rtl/amo_reservation_unit.sv - LR/SC reservation holder and combinational AMO ALU shared by memory sub-units.
module amo_reservation_unit #(
    parameter int NUM_PORTS  = 2,
    parameter int LR_TIMEOUT = 64,
    parameter int TIMER_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS-1:0]     set_reservation,
    input  logic [NUM_PORTS-1:0]     clear_reservation,
    input  logic [32*NUM_PORTS-1:0]  reservation,
    input  logic [NUM_PORTS-1:0]     rmw_valid,
    input  logic [5*NUM_PORTS-1:0]   op,
    input  logic [32*NUM_PORTS-1:0]  rs1,
    input  logic [32*NUM_PORTS-1:0]  rs2,
    input  logic                     snoop_valid,
    input  logic [31:0]              snoop_addr,
    output logic [NUM_PORTS-1:0]     reservation_valid,
    output logic [32*NUM_PORTS-1:0]  rd,
    output logic                     res_held,
    output logic [29:0]              res_addr
);

    localparam logic               TIMEOUT_EN = (LR_TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST = (LR_TIMEOUT == 0) ? '0 : TIMER_W'(LR_TIMEOUT - 1);

    logic               res_v;
    logic [29:0]        res_a;
    logic [TIMER_W-1:0] timer;

    logic               next_v;
    logic [29:0]        next_a;
    logic [TIMER_W-1:0] next_timer;

    logic               set_any;
    logic               clear_any;
    logic               snoop_hit;
    logic               timed_out;
    logic [29:0]        set_addr;
    logic [1:0]         unused_snoop_low;

    assign set_any          = |set_reservation;
    assign clear_any        = |clear_reservation;
    assign snoop_hit        = snoop_valid && res_v && (snoop_addr[31:2] == res_a);
    assign timed_out        = TIMEOUT_EN && res_v && (timer == TIMER_LAST);
    assign unused_snoop_low = snoop_addr[1:0];

    // Scan from the top so the lowest-numbered requesting port has the final say.
    always_comb begin
        set_addr = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (set_reservation[p]) begin
                set_addr = reservation[32*p+2 +: 30];
            end
        end
    end

    always_comb begin
        next_v     = res_v;
        next_a     = res_a;
        next_timer = timer;
        if (set_any) begin
            next_v     = 1'b1;
            next_a     = set_addr;
            next_timer = '0;
        end else if (clear_any) begin
            next_v = 1'b0;
        end else if (snoop_hit) begin
            next_v = 1'b0;
        end else if (timed_out) begin
            next_v = 1'b0;
        end else if (res_v && (timer != '1)) begin
            next_timer = timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_v <= 1'b0;
            res_a <= '0;
            timer <= '0;
        end else begin
            res_v <= next_v;
            res_a <= next_a;
            timer <= next_timer;
        end
    end

    assign res_held = res_v;
    assign res_addr = res_a;

    // Min/max share one 33-bit subtract; op[3] selects unsigned (zero-extend) vs signed.
    function automatic logic [31:0] amo_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        logic        ext;
        logic [32:0] diff;
        logic        lt;
        ext  = ~f[3];
        diff = {ext & a[31], a} - {ext & b[31], b};
        lt   = diff[32];
        case (f)
            5'b00000: amo_alu = a + b;
            5'b00001: amo_alu = b;
            5'b00100: amo_alu = a ^ b;
            5'b01100: amo_alu = a & b;
            5'b01000: amo_alu = a | b;
            5'b10000: amo_alu = lt ? a : b;
            5'b10100: amo_alu = lt ? b : a;
            5'b11000: amo_alu = lt ? a : b;
            5'b11100: amo_alu = lt ? b : a;
            default:  amo_alu = a;
        endcase
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [1:0] unused_res_low;
        assign unused_res_low       = reservation[32*p +: 2];
        assign reservation_valid[p] = res_v && (res_a == reservation[32*p+2 +: 30]);
        assign rd[32*p +: 32]       = rmw_valid[p] ? amo_alu(op[5*p +: 5], rs1[32*p +: 32], rs2[32*p +: 32])
                                                   : rs1[32*p +: 32];
    end

endmodule

// File: doc/amo_reservation_unit.md
Name: amo_reservation_unit

Overview:
- Responder end of the subunit AMO interface.
- Serves NUM_PORTS memory sub-units (local mem, dcache, ...), each of which drives set/clear/reservation/rmw/op/rs1/rs2 and consumes reservation_valid/rd.
- Holds the hart's single LR/SC reservation, with address match, timeout and snoop invalidation.
- Provides the combinational read-modify-write ALU that returns rd in the same cycle as rs1.

Parameters:
- NUM_PORTS, 2, number of sub-units attached; port index 0 has highest priority.
- LR_TIMEOUT, 64, cycles after a set before the reservation auto-expires; 0 disables the timeout.
- TIMER_W, 8, width of the timeout counter; must satisfy LR_TIMEOUT < 2**TIMER_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- set_reservation  in  NUM_PORTS  per port: LR request accepted this cycle
- clear_reservation  in  NUM_PORTS  per port: any new request this cycle
- reservation  in  32*NUM_PORTS  per port: request byte address; port p occupies bits [32p+31:32p]
- rmw_valid  in  NUM_PORTS  per port: RMW write cycle
- op  in  5*NUM_PORTS  per port: amo_t funct5
- rs1  in  32*NUM_PORTS  per port: memory read data
- rs2  in  32*NUM_PORTS  per port: registered store operand
- snoop_valid  in  1  external write observed
- snoop_addr  in  32  byte address of that external write
- reservation_valid  out  NUM_PORTS  per port: reservation held AND its address matches that port's reservation[31:2]
- rd  out  32*NUM_PORTS  per port: RMW result to write back
- res_held  out  1  debug: reservation register valid
- res_addr  out  30  debug: reserved word address

Behaviour:
- State: res_v (1b), res_a[31:2], timer[TIMER_W-1:0].
- Reset: res_v=0, res_a=0, timer=0; hence reservation_valid=0 and res_held=0. rd is combinational, so it has no reset value.
- reservation_valid[p] = res_v & (res_a == reservation[p][31:2]). Purely combinational from current state, with zero latency, so a sub-unit can gate an SC write in its request cycle.
- Next-state priority, highest first:
  1. Any set_reservation[p]: res_v<=1, res_a<=reservation[p][31:2] for the lowest p set, timer<=0.
  2. Else any clear_reservation: res_v<=0.
  3. Else snoop_valid & res_v & snoop_addr[31:2]==res_a: res_v<=0.
  4. Else LR_TIMEOUT!=0 & res_v & timer==LR_TIMEOUT-1: res_v<=0.
  5. Else if res_v: timer<=timer+1, saturating.
- Set in the same cycle as a clear or snoop on any port or address: set wins. The reservation reflects the newest LR.
- An SC checks validity in its request cycle (pre-update state) and clears it at the next edge, regardless of outcome.
- Timeout: with LR_TIMEOUT=N, res_v is held for exactly N cycles after the set edge, then drops.
- rd[p] is combinational from op[p], rs1[p] and rs2[p], and is valid whenever rmw_valid[p]=1. Otherwise it is don't-care, but it must not generate X from non-X inputs.
  - SWAP(00001): rd = rs2
  - ADD(00000): rd = rs1 + rs2, 32-bit wrap-around
  - XOR(00100), AND(01100), OR(01000): bitwise
  - MIN(10000), MAX(10100): signed compare
  - MINU(11000), MAXU(11100): unsigned compare
  - LR, SC or unknown op: rd = rs1 (write-back is a no-op)
- Compare implementation: 33-bit subtract with sign-extension chosen by op[3].
- rd has no internal state and no cross-port sharing. Simultaneous RMW on several ports is legal.
- rmw_valid does not modify the reservation; the sub-unit's clear already did.
- Reset mid-reservation: res_v drops at the reset edge and the timer returns to 0.

Test Plan:
- Reset, then LR on port0 at addr 0x100 -> next cycle res_held=1, res_addr=0x40; reservation_valid[0]=1 while reservation[0]=0x100, and 0 while 0x104.
- LR at 0x200, then SC (clear) 3 cycles later at 0x200 -> reservation_valid[0]=1 in the SC cycle, res_held=0 the cycle after; a second SC at 0x200 sees reservation_valid[0]=0.
- Same-cycle set on port1 (0x300) and clear on port0 -> res_held=1, res_addr=0xC0; set on port0 (0x10) and port1 (0x20) together -> res_addr=0x4.
- LR at 0x400, snoop_valid with snoop_addr=0x404 (different word) -> held; snoop_addr=0x402 (same word) -> res_held=0 next cycle. With LR_TIMEOUT=64 and no activity -> res_held drops exactly 64 cycles after the set edge.
- ALU sweep with rmw_valid=1, rs1=0xFFFFFFFE, rs2=0x00000003:
  - ADD -> 0x00000001
  - SWAP -> 0x3
  - AND -> 0x2
  - OR -> 0xFFFFFFFF
  - XOR -> 0xFFFFFFFD
  - MIN -> 0xFFFFFFFE
  - MAX -> 0x3
  - MINU -> 0x3
  - MAXU -> 0xFFFFFFFE
- Assert rst while res_held=1 and timer=10 -> res_held=0 and reservation_valid=0 next cycle; a new LR after reset times out at a full LR_TIMEOUT.
